// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory / MMIO responder: MMIO offsets,
// CON_STAT bit positions and the address-region type.
package dmem_pkg;

  localparam logic [11:0] OFF_CON_DATA = 12'h000;
  localparam logic [11:0] OFF_CON_STAT = 12'h004;
  localparam logic [11:0] OFF_MTIME_LO = 12'h008;
  localparam logic [11:0] OFF_MTIME_HI = 12'h00C;
  localparam logic [11:0] OFF_TOHOST   = 12'h010;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic {REG_RAM, REG_MMIO} region_e;

endpackage

// File: rtl/dmem_mmio_responder_sync_fifo.sv
// Single-clock FIFO; zero-latency head read, push while full is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data RAM plus MMIO page (console FIFO, mtime, tohost) on the core's M-stage port.
// Optional mtime counter is built only when DMEM_MTIME_EN is defined.
module dmem_mmio_responder
  import dmem_pkg::*;
#(
  parameter int          RAM_WORDS  = 1024,
  parameter logic [19:0] MMIO_PAGE  = 20'h80000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] readDataM,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam int IW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  region_e       region;
  logic [11:0]   offset;
  logic [IW-1:0] ram_idx;
  logic [31:0]   ram [RAM_WORDS];
  logic          mmio_wr, wr_con, wr_stat, wr_lo, wr_hi, wr_tohost;
  logic          fifo_full, fifo_empty, pop, drop, overflow;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic [31:0]   stat_word, mtime_lo, mtime_hi;

  assign region    = (ALUResultM[31:12] == MMIO_PAGE) ? REG_MMIO : REG_RAM;
  assign offset    = ALUResultM[11:0];
  assign ram_idx   = ALUResultM[2 +: IW];
  assign mmio_wr   = MemWriteM && (region == REG_MMIO);
  assign wr_con    = mmio_wr && (offset == OFF_CON_DATA);
  assign wr_stat   = mmio_wr && (offset == OFF_CON_STAT);
  assign wr_lo     = mmio_wr && (offset == OFF_MTIME_LO);
  assign wr_hi     = mmio_wr && (offset == OFF_MTIME_HI);
  assign wr_tohost = mmio_wr && (offset == OFF_TOHOST);

  always_ff @(posedge clk) begin
    if (MemWriteM && region == REG_RAM) ram[ram_idx] <= WriteDataM;
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_con_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_con),
    .din   (WriteDataM[7:0]),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head is masked while empty so stale storage never reaches the stream.
  assign con_valid = !fifo_empty;
  assign con_data  = fifo_empty ? 8'h00 : fifo_head;
  assign pop       = con_valid && con_ready;
  assign drop      = wr_con && fifo_full && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      halt      <= 1'b0;
      halt_code <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      else if (wr_stat && WriteDataM[STAT_OVERFLOW]) overflow <= 1'b0;
      if (wr_tohost && !halt && WriteDataM != '0) begin
        halt      <= 1'b1;
        halt_code <= WriteDataM;
      end
    end
  end

`ifdef DMEM_MTIME_EN
  logic [63:0] mtime;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     mtime <= '0;
    else if (wr_lo) mtime[31:0]  <= WriteDataM;
    else if (wr_hi) mtime[63:32] <= WriteDataM;
    else            mtime <= mtime + 64'd1;
  end

  assign mtime_lo = mtime[31:0];
  assign mtime_hi = mtime[63:32];
`else
  assign mtime_lo = '0;
  assign mtime_hi = '0;
`endif

  always_comb begin
    stat_word = '0;
    stat_word[STAT_FULL]            = fifo_full;
    stat_word[STAT_EMPTY]           = fifo_empty;
    stat_word[STAT_OVERFLOW]        = overflow;
    stat_word[STAT_COUNT_LSB +: 8]  = 8'(fifo_count);
  end

  always_comb begin
    readDataM = '0;
    if (region == REG_RAM) begin
      readDataM = ram[ram_idx];
    end else begin
      case (offset)
        OFF_CON_STAT: readDataM = stat_word;
        OFF_MTIME_LO: readDataM = mtime_lo;
        OFF_MTIME_HI: readDataM = mtime_hi;
        OFF_TOHOST:   readDataM = halt_code;
        default:      readDataM = '0;
      endcase
    end
  end

endmodule
